// File: rtl/commit_trace_fifo.sv
// Retirement trace FIFO: captures W-stage register writes and M-stage stores in
// program order and presents them show-ahead to a valid/ready reader.
module commit_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          grf_we,
    input  logic [4:0]    grf_addr,
    input  logic [31:0]   grf_wdata,
    input  logic [31:0]   grf_pc,
    input  logic          dm_we,
    input  logic [31:0]   dm_addr,
    input  logic [31:0]   dm_wdata,
    input  logic [31:0]   dm_pc,
    output logic          trace_valid,
    input  logic          trace_ready,
    output logic          trace_kind,
    output logic [31:0]   trace_pc,
    output logic [31:0]   trace_addr,
    output logic [31:0]   trace_data,
    output logic [AW:0]   trace_count,
    output logic          overflow,
    output logic [15:0]   drop_cnt
);

    // Entry layout: {kind, pc, addr, data}
    localparam int EW = 97;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr1;
    logic [AW:0]   count;

    logic          grf_ev, dm_ev, pop;
    logic          acc_grf, acc_dm;
    logic [AW+1:0] space, need_dm;
    logic [AW:0]   n_acc;
    logic [1:0]    n_drop;
    logic [EW-1:0] grf_ent, dm_ent, slot0_ent;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign grf_ev  = grf_we && (grf_addr != 5'd0);
    assign dm_ev   = dm_we;
    assign pop     = trace_valid && trace_ready;

    // A same-cycle pop frees a slot for this cycle's pushes; GRF (older) claims space first.
    assign space   = (AW+2)'(DEPTH) - {1'b0, count} + {{(AW+1){1'b0}}, pop};
    assign acc_grf = grf_ev && (space != '0);
    assign need_dm = acc_grf ? (AW+2)'(2) : (AW+2)'(1);
    assign acc_dm  = dm_ev && (space >= need_dm);

    assign n_acc   = {{AW{1'b0}}, acc_grf} + {{AW{1'b0}}, acc_dm};
    assign n_drop  = {1'b0, grf_ev & ~acc_grf} + {1'b0, dm_ev & ~acc_dm};

    assign grf_ent   = {1'b0, grf_pc, {27'b0, grf_addr}, grf_wdata};
    assign dm_ent    = {1'b1, dm_pc, dm_addr, dm_wdata};
    assign slot0_ent = acc_grf ? grf_ent : dm_ent;
    assign wr_ptr1   = wr_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (acc_grf || acc_dm)
            mem[wr_ptr] <= slot0_ent;
        if (acc_grf && acc_dm)
            mem[wr_ptr1] <= dm_ent;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= 16'd0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(n_acc);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count    <= count + n_acc - {{AW{1'b0}}, pop};
            overflow <= overflow | (n_drop != 2'd0);
            drop_cnt <= sat_add16(drop_cnt, n_drop);
        end
    end

    // Show-ahead head; fields forced to zero while empty so reset clears them at once.
    always_comb begin
        trace_valid = (count != '0);
        trace_count = count;
        trace_kind  = 1'b0;
        trace_pc    = 32'd0;
        trace_addr  = 32'd0;
        trace_data  = 32'd0;
        if (count != '0) begin
            {trace_kind, trace_pc, trace_addr, trace_data} = mem[rd_ptr];
        end
    end

endmodule
